// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, imported by the timing
// generator and by any renderer that needs to agree on the raster geometry.
package vga_timing_pkg;

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    // Bit order of the delayed control bundle; the reset value is idle sync, blanked.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bits_t;

    localparam sync_bits_t SYNC_BITS_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    // Half-open window test lo <= pos < hi, used for the sync pulses.
    function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Parameterised shift register that delays a small control bundle by DEPTH
// cycles; every stage loads RESET_VAL while reset is low.
module sync_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unusedPins;
            assign unusedPins = clk_i & rst_ni;
            assign data_o     = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= RESET_VAL;
                    end
                end else begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered position,
// blank, sync and start strobes, plus a sync/blank copy delayed for the renderer.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       line_start,
    output logic       frame_start
);

    // All window bounds are folded to 10-bit constants at elaboration.
    localparam coord_t H_MAX      = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_MAX      = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t hc_q, hc_d;
    coord_t vc_q, vc_d;
    coord_t drawX_q, drawY_q;
    logic   vis_q, vis_d;
    logic   hSync_q, hSync_d;
    logic   vSync_q, vSync_d;
    logic   lineStart_q, lineStart_d;
    logic   frameStart_q, frameStart_d;

    sync_bits_t delayIn;
    sync_bits_t delayOut;

    // Outputs are decoded from the next counter values so that, once
    // registered, they describe the same (hc,vc) the counters move to.
    always_comb begin
        hc_d         = hc_q;
        vc_d         = vc_q;
        vis_d        = 1'b0;
        hSync_d      = 1'b1;
        vSync_d      = 1'b1;
        lineStart_d  = 1'b0;
        frameStart_d = 1'b0;

        if (hc_q == H_MAX) begin
            hc_d = '0;
            vc_d = (vc_q == V_MAX) ? coord_t'(0) : vc_q + coord_t'(1);
        end else begin
            hc_d = hc_q + coord_t'(1);
        end

        vis_d        = (hc_d < H_VIS_END) && (vc_d < V_VIS_END);
        hSync_d      = ~in_window(hc_d, HS_START, HS_END);
        vSync_d      = ~in_window(vc_d, VS_START, VS_END);
        lineStart_d  = (hc_d == '0);
        frameStart_d = (hc_d == '0) && (vc_d == '0);
    end

    // Counters park at the last pixel during reset so the first released
    // edge wraps both to zero and raises both start strobes.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_q         <= H_MAX;
            vc_q         <= V_MAX;
            drawX_q      <= '0;
            drawY_q      <= '0;
            vis_q        <= 1'b0;
            hSync_q      <= 1'b1;
            vSync_q      <= 1'b1;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            drawX_q      <= hc_d;
            drawY_q      <= vc_d;
            vis_q        <= vis_d;
            hSync_q      <= hSync_d;
            vSync_q      <= vSync_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign delayIn = '{hs: hSync_q, vs: vSync_q, blank: vis_q};

    sync_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (SYNC_BITS_IDLE)
    ) u_sync_delay (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .data_i (delayIn),
        .data_o (delayOut)
    );

    assign DrawX       = drawX_q;
    assign DrawY       = drawY_q;
    assign blank       = vis_q;
    assign hs          = hSync_q;
    assign vs          = vSync_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;
    assign hs_d        = delayOut.hs;
    assign vs_d        = delayOut.vs;
    assign blank_d     = delayOut.blank;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL take parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL take parameters H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal front porch, sync and back porch widths in pixels; H_TOTAL = sum of the four = 800.
REQ-003 SHALL take parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33, meaning the vertical equivalents in lines; V_TOTAL = 525.
REQ-004 SHALL take parameter PIPE_DELAY, default 2, range 0..4, meaning the sync/blank delay matching a downstream ROM-plus-register renderer.
REQ-005 SHALL have port vga_clk  input  1  pixel clock; single clock domain.
REQ-006 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port DrawX  output  10  current horizontal position 0..H_TOTAL-1.
REQ-008 SHALL have port DrawY  output  10  current vertical position 0..V_TOTAL-1.
REQ-009 SHALL have port blank  output  1  1 = visible pixel (renderer drives colour), 0 = blanking.
REQ-010 SHALL have ports hs and vs  output  1 each  horizontal/vertical sync, active-low, aligned with DrawX/DrawY.
REQ-011 SHALL have ports hs_d, vs_d, blank_d  output  1 each  hs, vs and blank delayed PIPE_DELAY cycles.
REQ-012 SHALL have ports line_start and frame_start  output  1 each  single-cycle strobes.

Function
REQ-013 SHALL keep a horizontal counter hc 0..H_TOTAL-1 that increments once per vga_clk and wraps H_TOTAL-1 -> 0.
REQ-014 SHALL keep a vertical counter vc that increments only on the cycle where hc wraps, and wraps V_TOTAL-1 -> 0 on that same cycle.
REQ-015 SHALL register every output so that outputs change on the same edge as the counters and always describe the new (hc,vc); DrawX=hc, DrawY=vc.
REQ-016 SHALL drive blank=1 iff hc<H_VISIBLE and vc<V_VISIBLE; blank=0 at hc=640 and at every pixel of vc>=480.
REQ-017 SHALL drive hs=0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751), else 1.
REQ-018 SHALL drive vs=0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491) for the whole line, else 1.
REQ-019 SHALL assert line_start for exactly the cycle with hc=0, and frame_start for exactly the cycle with hc=0 and vc=0; both assert together on that cycle.
REQ-020 SHALL produce hs_d/vs_d/blank_d as a PIPE_DELAY-deep shift of hs/vs/blank; with PIPE_DELAY=0 they equal hs/vs/blank.
REQ-021 SHALL use 10-bit unsigned arithmetic; comparisons SHALL be computed from parameters at elaboration, with no runtime multiply or divide.

Reset
REQ-022 SHALL, on any edge with reset_n=0, load internal counters to (H_TOTAL-1, V_TOTAL-1) and drive DrawX=0, DrawY=0, blank=0, hs=1, vs=1, line_start=0, frame_start=0, and fill every delay stage with hs_d=1, vs_d=1, blank_d=0.
REQ-023 SHALL, on the first edge with reset_n=1, present DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
REQ-024 SHALL, when reset is asserted mid-frame, abandon the frame on the next edge with no partial sync pulse extension, and restart at (0,0) as in REQ-023.

Structure
REQ-025 SHALL take all timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL, sync start/end positions) from shared package vga_timing_pkg, which other renderers also import.
REQ-026 SHALL implement the delay line as one sub-module, sync_delay, parameterised by WIDTH and DEPTH with reset value per bit; vga_timing_gen SHALL instantiate it once with WIDTH=3.

Verification
REQ-027 Release reset after 5 cycles -> first edge: DrawX=0, DrawY=0, blank=1, frame_start=1; next cycle DrawX=1, frame_start=0.
REQ-028 Run one line -> hs falls when DrawX=656, rises when DrawX=752 (96 cycles low); blank falls at DrawX=640; at DrawX=799 -> next DrawX=0, DrawY+1, line_start=1.
REQ-029 Run two frames -> frame_start pulses exactly 420000 cycles apart; vs low exactly 1600 cycles starting at DrawY=490, DrawX=0; DrawY=524, DrawX=799 -> next (0,0).
REQ-030 PIPE_DELAY=2 -> hs_d, vs_d, blank_d equal hs, vs, blank from 2 cycles earlier across a line wrap; PIPE_DELAY=0 -> identical.
REQ-031 Assert reset_n=0 at DrawX=700, DrawY=100 (hs low) -> next edge hs=1, blank=0, hs_d=1; release -> restart per REQ-027.
REQ-032 Assert reset_n=0 at DrawY=491 (vs low) for 1 cycle -> vs=1 on next edge; no frame_start until reset releases.
